sample_fifo: RTL and testbench

Write-side buffer directly upstream of the per-channel sample counter: accepts ADC sample words from the capture path, stores them in a small flop-based FIFO, and presents them to the DMA side with valid/ready. Produces the `wr_en` strobe and the registered `wr_overflow` flag the counter consumes, so the counter tallies only samples actually stored. Flushed on channel disable; overflow state re-armed on each channel-enable rising edge.

---
 rtl/sample_fifo_pkg.sv | 12 +
 rtl/rise_detect.sv | 18 +
 rtl/sample_fifo.sv | 83 ++++++++
 tb/tb_sample_fifo.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/sample_fifo_pkg.sv
// Shared defaults for the sample FIFO and helpers sized from them.
package sample_fifo_pkg;

  localparam int DATA_WIDTH_DEF = 64;
  localparam int DEPTH_LOG2_DEF = 4;

  // Occupancy must represent 0..2^depth_log2 inclusive.
  function automatic int level_width(input int depth_log2);
    return depth_log2 + 1;
  endfunction

endpackage

// File: rtl/rise_detect.sv
// Registers a level signal and flags the cycle in which it goes from low to high.
module rise_detect (
  input  logic clk,
  input  logic rstn,
  input  logic din,
  output logic rise
);

  logic din_q;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) din_q <= 1'b0;
    else       din_q <= din;
  end

  assign rise = din & ~din_q;

endmodule

// File: rtl/sample_fifo.sv
// Flop-based first-word-fall-through sample buffer with drop detection.
// Feeds the per-channel sample counter: wr_en strobe plus a registered overflow flag.
module sample_fifo
  import sample_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int DEPTH_LOG2 = DEPTH_LOG2_DEF
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               chan_enable,
  input  logic                               in_valid,
  input  logic [DATA_WIDTH-1:0]              in_data,
  output logic                               wr_en,
  output logic                               wr_overflow,
  output logic                               out_valid,
  output logic [DATA_WIDTH-1:0]              out_data,
  input  logic                               out_ready,
  output logic [level_width(DEPTH_LOG2)-1:0] level,
  output logic                               overflow_sticky
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int LW    = level_width(DEPTH_LOG2);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr, wr_addr;
  logic [LW-1:0]         count;
  logic                  en_rise, full, rd_fire, wr_ok, wr_drop;

  rise_detect u_rise (
    .clk  (clk),
    .rstn (rstn),
    .din  (chan_enable),
    .rise (en_rise)
  );

  // The enable gate keeps outputs empty in the very cycle the channel drops,
  // before the registered flush has taken effect.
  assign wr_en     = in_valid & chan_enable;
  assign out_valid = chan_enable & (count != '0);
  assign level     = chan_enable ? count : '0;
  assign out_data  = mem[rd_ptr];

  assign full    = (count == LW'(DEPTH));
  assign rd_fire = out_valid & out_ready & ~en_rise;
  assign wr_ok   = wr_en & (en_rise | ~full | rd_fire);
  assign wr_drop = wr_en & ~wr_ok;
  assign wr_addr = en_rise ? '0 : wr_ptr;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      wr_overflow     <= 1'b0;
      overflow_sticky <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (!chan_enable) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      wr_overflow <= 1'b0;
    end else begin
      wr_overflow <= wr_drop;
      if (wr_drop)      overflow_sticky <= 1'b1;
      else if (en_rise) overflow_sticky <= 1'b0;

      if (en_rise) begin
        rd_ptr <= '0;
        wr_ptr <= DEPTH_LOG2'(wr_ok);
        count  <= LW'(wr_ok);
      end else begin
        if (wr_ok)   wr_ptr <= wr_ptr + 1'b1;
        if (rd_fire) rd_ptr <= rd_ptr + 1'b1;
        count <= count + LW'(wr_ok) - LW'(rd_fire);
      end

      if (wr_ok) mem[wr_addr] <= in_data;
    end
  end

endmodule

// File: tb/tb_sample_fifo.sv
// Self-checking bench for sample_fifo: queue-based reference model, per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_sample_fifo;

  localparam int DW    = 64;
  localparam int DL    = 2;
  localparam int DEPTH = 1 << DL;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          chan_enable = 1'b0;
  logic          in_valid = 1'b0;
  logic          out_ready = 1'b0;
  logic [DW-1:0] in_data = '0;
  logic          wr_en, wr_overflow, out_valid, overflow_sticky;
  logic [DW-1:0] out_data;
  logic [DL:0]   level;

  int checks = 0;
  int errors = 0;

  sample_fifo #(.DATA_WIDTH(DW), .DEPTH_LOG2(DL)) dut (
    .clk             (clk),
    .rstn            (rstn),
    .chan_enable     (chan_enable),
    .in_valid        (in_valid),
    .in_data         (in_data),
    .wr_en           (wr_en),
    .wr_overflow     (wr_overflow),
    .out_valid       (out_valid),
    .out_data        (out_data),
    .out_ready       (out_ready),
    .level           (level),
    .overflow_sticky (overflow_sticky)
  );

  always #5 clk = ~clk;

  task automatic cmp(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: a queue of stored words plus the two overflow flags.
  logic [DW-1:0] mq[$];
  bit m_ovf = 0, m_sticky = 0, m_en_prev = 0;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mq.delete();
      m_ovf = 0; m_sticky = 0; m_en_prev = 0;
    end else begin
      if (!chan_enable) begin
        mq.delete();
        m_ovf = 0;
      end else begin
        if (!m_en_prev) begin
          mq.delete();
          m_sticky = 0;
        end
        if (out_ready && mq.size() > 0) void'(mq.pop_front());
        if (in_valid) begin
          if (mq.size() < DEPTH) begin
            mq.push_back(in_data);
            m_ovf = 0;
          end else begin
            m_ovf = 1;
            m_sticky = 1;
          end
        end else m_ovf = 0;
      end
      m_en_prev = chan_enable;
    end
  end

  always @(negedge clk) begin
    bit ev;
    ev = chan_enable && (mq.size() > 0);
    cmp("wr_en", wr_en, in_valid & chan_enable);
    cmp("wr_overflow", wr_overflow, m_ovf);
    cmp("overflow_sticky", overflow_sticky, m_sticky);
    cmp("out_valid", out_valid, ev);
    cmp("level", level, chan_enable ? mq.size() : 0);
    if (ev) cmp("out_data", out_data, mq[0]);
  end

  task automatic step(input bit en, input bit v, input logic [DW-1:0] d, input bit rdy);
    chan_enable = en; in_valid = v; in_data = d; out_ready = rdy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [DW-1:0] exp_a [3];
    logic [DW-1:0] exp_b [4];
    int rdy_pct;
    exp_a = '{64'h11, 64'h22, 64'h33};
    exp_b = '{64'h42, 64'h43, 64'h44, 64'h66};

    repeat (3) @(posedge clk);
    #1;
    cmp("rst_level", level, 0);
    cmp("rst_out_valid", out_valid, 0);
    cmp("rst_out_data", out_data, 0);
    cmp("rst_wr_overflow", wr_overflow, 0);
    cmp("rst_sticky", overflow_sticky, 0);
    rstn = 1'b1;
    cmp("rel_level", level, 0);
    cmp("rel_out_data", out_data, 0);

    step(1, 1, 64'h11, 0);
    step(1, 1, 64'h22, 0);
    step(1, 1, 64'h33, 0);
    cmp("three_level", level, 3);
    for (int i = 0; i < 3; i++) begin
      cmp("three_order", out_data, exp_a[i]);
      step(1, 0, '0, 1);
    end
    cmp("three_drained", level, 0);
    cmp("three_empty", out_valid, 0);

    for (int i = 0; i < 4; i++) step(1, 1, 64'h41 + 64'(i), 0);
    cmp("fill_level", level, 4);
    step(1, 1, 64'h55, 0);
    cmp("drop_ovf", wr_overflow, 1);
    cmp("drop_sticky", overflow_sticky, 1);
    cmp("drop_level", level, 4);
    step(1, 0, '0, 0);
    cmp("drop_ovf_once", wr_overflow, 0);
    cmp("drop_sticky_hold", overflow_sticky, 1);

    step(1, 1, 64'h66, 1);
    cmp("fullrd_ovf", wr_overflow, 0);
    cmp("fullrd_level", level, 4);
    for (int i = 0; i < 4; i++) begin
      cmp("fullrd_order", out_data, exp_b[i]);
      step(1, 0, '0, 1);
    end
    cmp("fullrd_drained", level, 0);

    step(1, 1, 64'h81, 0);
    step(1, 1, 64'h82, 0);
    cmp("en_pre_level", level, 2);
    cmp("en_pre_sticky", overflow_sticky, 1);
    step(0, 1, 64'h99, 0);
    cmp("en_low_level", level, 0);
    cmp("en_low_valid", out_valid, 0);
    cmp("en_low_wr_en", wr_en, 0);
    step(1, 1, 64'h77, 0);
    in_valid = 1'b0;
    cmp("en_rise_level", level, 1);
    cmp("en_rise_data", out_data, 64'h77);
    cmp("en_rise_sticky", overflow_sticky, 0);
    cmp("en_rise_ovf", wr_overflow, 0);

    step(1, 0, '0, 1);
    step(1, 1, 64'hA1, 0);
    step(1, 1, 64'hA2, 0);
    step(1, 1, 64'hA3, 0);
    cmp("burst_level", level, 3);
    #2 rstn = 1'b0;
    #1;
    cmp("midrst_level", level, 0);
    cmp("midrst_valid", out_valid, 0);
    cmp("midrst_data", out_data, 0);
    cmp("midrst_sticky", overflow_sticky, 0);
    @(posedge clk);
    #1 rstn = 1'b1;
    step(1, 1, 64'hB1, 0);
    in_valid = 1'b0;
    cmp("postrst_level", level, 1);
    cmp("postrst_data", out_data, 64'hB1);
    step(1, 0, '0, 1);

    rdy_pct = 50;
    for (int n = 0; n < 4000; n++) begin
      if (n % 200 == 0) rdy_pct = (n / 200) % 3 == 0 ? 15 : ((n / 200) % 3 == 1 ? 50 : 90);
      step($urandom_range(0, 24) != 0, $urandom_range(0, 99) < 60,
           {$urandom(), $urandom()}, $urandom_range(0, 99) < rdy_pct);
      if ($urandom_range(0, 799) == 0) begin
        #2 rstn = 1'b0;
        @(posedge clk);
        #1 rstn = 1'b1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
